// File: rtl/msrv32_ifetch_unit_if.sv
// Fetch-side bundle: PC/flush from the pipeline, instruction-memory request/response,
// and the decoded-instruction handshake towards decode.
interface msrv32_ifetch_unit_if;
    logic [31:0] pc_in;
    logic        flush_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        pc_advance_out;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_ready_in;
    logic        misaligned_out;

    modport master (
        input  pc_in, flush_in, imem_gnt_in, imem_rvalid_in, imem_rdata_in, instr_ready_in,
        output imem_req_out, imem_addr_out, pc_advance_out, instr_valid_out, instr_out,
               instr_pc_out, misaligned_out
    );

    modport slave (
        output pc_in, flush_in, imem_gnt_in, imem_rvalid_in, imem_rdata_in, instr_ready_in,
        input  imem_req_out, imem_addr_out, pc_advance_out, instr_valid_out, instr_out,
               instr_pc_out, misaligned_out
    );
endinterface

// File: rtl/msrv32_ifetch_unit.sv
// Instruction-fetch front end: credit-limited imem requests, PC tag queue, response FIFO
// towards decode, and flush handling that drains responses still in flight.
module msrv32_ifetch_unit_chk #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = 2
) (
    input logic          clk_in,
    input logic          rst_in,
    input logic          push_s,
    input logic [CW-1:0] fifo_count_q
);
    // A push into a full FIFO means the credit accounting has broken
    always @(posedge clk_in) begin
        if (!rst_in) begin
            assert (!(push_s && (fifo_count_q >= CW'(DEPTH))));
        end
    end
endmodule

module msrv32_ifetch_unit #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input logic                  clk_in,
    input logic                  rst_in,
    msrv32_ifetch_unit_if.master bus
);
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW      = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          misaligned_q, misaligned_d;
    logic [31:0]   tag_pc_q     [DEPTH];
    logic [31:0]   tag_pc_d     [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_pc_d    [DEPTH];

    logic [CW:0]   credit_used_s;
    logic [CW-1:0] out_next_s;
    logic          req_s, grant_s, rv_ok_s, push_s, drop_s, pop_s, valid_s;

    assign credit_used_s = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    assign valid_s       = (fifo_count_q != CW'(0));

    // Request qualification and per-cycle event strobes
    always_comb begin
        req_s = 1'b0;
        if (!rst_in && (state_q == ST_RUN) && (bus.pc_in[1:0] == 2'b00) && !misaligned_q &&
            !bus.flush_in && (credit_used_s < DEPTH_C)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        grant_s    = req_s & bus.imem_gnt_in;
        rv_ok_s    = bus.imem_rvalid_in && (outstanding_q != CW'(0));
        // A response landing in the flush cycle is stale and never enters the FIFO
        push_s     = rv_ok_s && (discard_q == CW'(0)) && !bus.flush_in;
        drop_s     = rv_ok_s && (discard_q != CW'(0));
        pop_s      = valid_s && bus.instr_ready_in && !bus.flush_in;
        out_next_s = outstanding_q + CW'(grant_s) - CW'(rv_ok_s);
    end

    // FSM next state: discard counts responses still owed to a redirected stream
    always_comb begin
        state_d       = state_q;
        discard_d     = discard_q;
        outstanding_d = out_next_s;
        if (bus.flush_in) begin
            discard_d = out_next_s;
            state_d   = (out_next_s != CW'(0)) ? ST_DRAIN : ST_RUN;
        end else begin
            discard_d = drop_s ? (discard_q - CW'(1)) : discard_q;
            case (state_q)
                ST_RUN:   state_d = ST_RUN;
                ST_DRAIN: state_d = (discard_d == CW'(0)) ? ST_RUN : ST_DRAIN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // Tag queue, instruction FIFO and sticky misalign flag
    always_comb begin
        tag_pc_d     = tag_pc_q;
        tag_wr_d     = tag_wr_q;
        tag_rd_d     = tag_rd_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        misaligned_d = misaligned_q;
        if (grant_s) begin
            tag_pc_d[tag_wr_q] = bus.pc_in;
            tag_wr_d           = tag_wr_q + AW'(1);
        end else begin
            tag_wr_d = tag_wr_q;
        end
        if (rv_ok_s) begin
            tag_rd_d = tag_rd_q + AW'(1);
        end else begin
            tag_rd_d = tag_rd_q;
        end
        if (bus.flush_in) begin
            wr_ptr_d     = AW'(0);
            rd_ptr_d     = AW'(0);
            fifo_count_d = CW'(0);
            misaligned_d = 1'b0;
        end else begin
            if (push_s) begin
                fifo_instr_d[wr_ptr_q] = bus.imem_rdata_in;
                fifo_pc_d[wr_ptr_q]    = tag_pc_q[tag_rd_q];
                wr_ptr_d               = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            fifo_count_d = fifo_count_q + CW'(push_s) - CW'(pop_s);
            if ((state_q == ST_RUN) && (bus.pc_in[1:0] != 2'b00) &&
                (fifo_count_q == CW'(0)) && (outstanding_q == CW'(0))) begin
                misaligned_d = 1'b1;
            end else begin
                misaligned_d = misaligned_q;
            end
        end
    end

    // Control registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_RUN;
            outstanding_q <= CW'(0);
            discard_q     <= CW'(0);
            fifo_count_q  <= CW'(0);
            tag_wr_q      <= AW'(0);
            tag_rd_q      <= AW'(0);
            wr_ptr_q      <= AW'(0);
            rd_ptr_q      <= AW'(0);
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fifo_count_q  <= fifo_count_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // Payload storage; validity is tracked by the counters above
    always_ff @(posedge clk_in) begin
        tag_pc_q     <= tag_pc_d;
        fifo_instr_q <= fifo_instr_d;
        fifo_pc_q    <= fifo_pc_d;
    end

    assign bus.imem_req_out    = req_s;
    assign bus.imem_addr_out   = bus.pc_in;
    assign bus.pc_advance_out  = grant_s;
    assign bus.instr_valid_out = valid_s;
    assign bus.instr_out       = valid_s ? fifo_instr_q[rd_ptr_q] : NOP;
    assign bus.instr_pc_out    = valid_s ? fifo_pc_q[rd_ptr_q] : BOOT_ADDR;
    assign bus.misaligned_out  = misaligned_q;

    msrv32_ifetch_unit_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .push_s       (push_s),
        .fifo_count_q (fifo_count_q)
    );
endmodule

// File: tb/tb_msrv32_ifetch_unit.sv
// Randomised bench for msrv32_ifetch_unit: a queue-based reference of the fetch stream plus
// an in-order memory responder, with directed scenarios layered on top.
module tb_msrv32_ifetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] BOOT  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    msrv32_ifetch_unit_if ifc();
    msrv32_ifetch_unit #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (.clk_in(clk), .rst_in(rst), .bus(ifc));

    int n_checks = 0;
    int n_fail   = 0;

    int          inflight, stale, buffered, cyc_n, extra_lat;
    bit          mis;
    logic [31:0] exp_q[$];
    logic [31:0] resp_addr[$];
    int          resp_due[$];
    logic [31:0] cur_pc;
    logic [31:0] pop_pc_log[$];
    logic [31:0] pop_ins_log[$];
    logic [31:0] grant_log[$];
    logic        obs_req, obs_mis, obs_adv, obs_rv, last_grant;
    logic [31:0] preload [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (preload.exists(a)) return preload[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic model_reset();
        inflight = 0; stale = 0; buffered = 0; mis = 1'b0;
        exp_q.delete(); resp_addr.delete(); resp_due.delete();
    endtask

    task automatic clear_logs();
        pop_pc_log.delete(); pop_ins_log.delete(); grant_log.delete();
    endtask

    // One clock: drive, compare against the reference at negedge, then advance the reference.
    task automatic cyc(input logic [31:0] pc, input logic fl, input logic gnt, input logic rdy,
                       input logic rv_en);
        logic exp_req, grant, rv, pop, mis_nxt;
        ifc.pc_in = pc; ifc.flush_in = fl; ifc.imem_gnt_in = gnt; ifc.instr_ready_in = rdy;
        rv = rv_en && (resp_addr.size() > 0);
        if (rv) rv = (resp_due[0] <= cyc_n);
        ifc.imem_rvalid_in = rv;
        ifc.imem_rdata_in  = rv ? mem_word(resp_addr[0]) : 32'($urandom());
        @(negedge clk);
        exp_req = (stale == 0) && (pc[1:0] == 2'b00) && !mis && !fl && (inflight + buffered < DEPTH);
        n_checks++;
        if (ifc.imem_req_out !== exp_req) begin
            n_fail++; $display("FAIL req cyc=%0d got=%b expected=%b", cyc_n, ifc.imem_req_out, exp_req);
        end
        n_checks++;
        if (ifc.pc_advance_out !== (exp_req & gnt)) begin
            n_fail++; $display("FAIL pc_advance cyc=%0d got=%b expected=%b", cyc_n, ifc.pc_advance_out, exp_req & gnt);
        end
        if (exp_req) begin
            n_checks++;
            if (ifc.imem_addr_out !== pc) begin
                n_fail++; $display("FAIL addr cyc=%0d got=%h expected=%h", cyc_n, ifc.imem_addr_out, pc);
            end
        end
        n_checks++;
        if (ifc.instr_valid_out !== (buffered > 0)) begin
            n_fail++; $display("FAIL instr_valid cyc=%0d got=%b expected=%b", cyc_n, ifc.instr_valid_out, buffered > 0);
        end
        if (buffered > 0) begin
            n_checks++;
            if (ifc.instr_pc_out !== exp_q[0] || ifc.instr_out !== mem_word(exp_q[0])) begin
                n_fail++; $display("FAIL head cyc=%0d got pc=%h ins=%h expected pc=%h ins=%h", cyc_n,
                                   ifc.instr_pc_out, ifc.instr_out, exp_q[0], mem_word(exp_q[0]));
            end
        end
        n_checks++;
        if (ifc.misaligned_out !== mis) begin
            n_fail++; $display("FAIL misaligned cyc=%0d got=%b expected=%b", cyc_n, ifc.misaligned_out, mis);
        end
        obs_req = ifc.imem_req_out; obs_mis = ifc.misaligned_out; obs_adv = ifc.pc_advance_out; obs_rv = rv;
        grant = exp_req & gnt;
        pop   = (buffered > 0) && rdy && !fl;
        if (pop) begin
            pop_pc_log.push_back(ifc.instr_pc_out);
            pop_ins_log.push_back(ifc.instr_out);
        end
        @(posedge clk); #1;
        cyc_n++;
        mis_nxt = fl ? 1'b0 : (mis | ((stale == 0) && (pc[1:0] != 2'b00) && (buffered == 0) && (inflight == 0)));
        if (rv) begin
            void'(resp_addr.pop_front()); void'(resp_due.pop_front());
            inflight--;
        end
        if (fl) begin
            stale = inflight; buffered = 0; exp_q.delete();
        end else begin
            if (rv) begin
                if (stale > 0) stale--;
                else buffered++;
            end
            if (pop) begin buffered--; void'(exp_q.pop_front()); end
            if (grant) begin inflight++; exp_q.push_back(pc); end
        end
        mis = mis_nxt;
        if (grant) begin
            resp_addr.push_back(pc);
            resp_due.push_back(cyc_n + int'($urandom_range(0, extra_lat)));
            grant_log.push_back(pc);
            cur_pc = pc + 32'd4;
        end
        last_grant = grant;
    endtask

    task automatic quiesce();
        for (int i = 0; i < 60 && (inflight + buffered > 0); i++) cyc(cur_pc, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (inflight + buffered != 0) begin
            n_fail++; $display("FAIL quiesce_timeout inflight=%0d buffered=%0d expected 0", inflight, buffered);
        end
    endtask

    task automatic test_reset();
        ifc.pc_in = 32'h0; ifc.flush_in = 1'b0; ifc.imem_gnt_in = 1'b1; ifc.imem_rvalid_in = 1'b0;
        ifc.imem_rdata_in = 32'h0; ifc.instr_ready_in = 1'b1;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ifc.imem_req_out !== 1'b0 || ifc.pc_advance_out !== 1'b0 || ifc.instr_valid_out !== 1'b0 ||
            ifc.misaligned_out !== 1'b0 || ifc.instr_out !== NOP || ifc.instr_pc_out !== BOOT) begin
            n_fail++; $display("FAIL reset_values got req=%b adv=%b v=%b mis=%b ins=%h pc=%h expected 0 0 0 0 %h %h",
                               ifc.imem_req_out, ifc.pc_advance_out, ifc.instr_valid_out, ifc.misaligned_out,
                               ifc.instr_out, ifc.instr_pc_out, NOP, BOOT);
        end
        @(posedge clk); #1 rst = 1'b0;
        model_reset(); cyc_n = 0;
    endtask

    task automatic test_basic_fetch();
        logic [31:0] e_ins [3];
        e_ins[0] = 32'h0050_0093; e_ins[1] = 32'h00A0_0113; e_ins[2] = 32'h0020_81B3;
        clear_logs(); extra_lat = 0; cur_pc = 32'h0;
        for (int i = 0; i < 30 && pop_pc_log.size() < 3; i++) cyc(cur_pc, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (pop_pc_log.size() < 3) begin
            n_fail++; $display("FAIL basic_timeout pops=%0d expected 3", pop_pc_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (pop_pc_log[i] !== 32'(4 * i) || pop_ins_log[i] !== e_ins[i]) begin
                    n_fail++; $display("FAIL basic_seq[%0d] got pc=%h ins=%h expected pc=%h ins=%h", i,
                                       pop_pc_log[i], pop_ins_log[i], 32'(4 * i), e_ins[i]);
                end
            end
        end
        quiesce();
    endtask

    task automatic test_backpressure();
        int grants;
        logic [31:0] start;
        clear_logs(); extra_lat = 0; grants = 0; start = cur_pc;
        for (int i = 0; i < 8; i++) begin
            cyc(cur_pc, 1'b0, 1'b1, 1'b0, 1'b1);
            grants += int'(obs_adv);
        end
        n_checks++;
        if (grants != DEPTH || obs_req !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_credit got grants=%0d req=%b expected %0d 0", grants, obs_req, DEPTH);
        end
        for (int i = 0; i < 12; i++) cyc(cur_pc, 1'b0, 1'b1, 1'b1, 1'b1);
        quiesce();
        n_checks++;
        if (pop_pc_log.size() != grant_log.size() || pop_pc_log.size() < 4) begin
            n_fail++; $display("FAIL backpressure_count got pops=%0d expected %0d", pop_pc_log.size(), grant_log.size());
        end
        for (int i = 0; i < pop_pc_log.size(); i++) begin
            n_checks++;
            if (pop_pc_log[i] !== start + 32'(4 * i) || pop_ins_log[i] !== mem_word(start + 32'(4 * i))) begin
                n_fail++; $display("FAIL backpressure_order[%0d] got pc=%h expected %h", i, pop_pc_log[i], start + 32'(4 * i));
            end
        end
    endtask

    task automatic test_flush();
        int grants;
        clear_logs(); extra_lat = 0; grants = 0; cur_pc = 32'h10;
        for (int i = 0; i < 10 && inflight < 2; i++) begin
            cyc(cur_pc, 1'b0, 1'b1, 1'b1, 1'b0);
            grants += int'(obs_adv);
        end
        n_checks++;
        if (grants != 2) begin
            n_fail++; $display("FAIL flush_setup got grants=%0d expected 2", grants);
        end
        cur_pc = 32'h100;
        cyc(cur_pc, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(cur_pc, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs_req !== 1'b0) begin
            n_fail++; $display("FAIL req_in_drain got=%b expected=0", obs_req);
        end
        for (int i = 0; i < 30 && pop_pc_log.size() < 1; i++) cyc(cur_pc, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (pop_pc_log.size() < 1 || pop_pc_log[0] !== 32'h100 || pop_ins_log[0] !== mem_word(32'h100)) begin
            n_fail++; $display("FAIL flush_first_pc got pops=%0d pc=%h expected 00000100", pop_pc_log.size(),
                               (pop_pc_log.size() > 0) ? pop_pc_log[0] : 32'hx);
        end
        quiesce();
    endtask

    task automatic test_misalign();
        quiesce(); clear_logs();
        cyc(32'h102, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(32'h102, 1'b0, 1'b1, 1'b1, 1'b1);
            n_checks++;
            if (obs_mis !== 1'b1 || obs_req !== 1'b0) begin
                n_fail++; $display("FAIL misalign_hold[%0d] got mis=%b req=%b expected 1 0", i, obs_mis, obs_req);
            end
        end
        cur_pc = 32'h200;
        cyc(cur_pc, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(cur_pc, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs_mis !== 1'b0) begin
            n_fail++; $display("FAIL misalign_clear got=%b expected=0", obs_mis);
        end
        for (int i = 0; i < 20 && pop_pc_log.size() < 1; i++) cyc(cur_pc, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (pop_pc_log.size() < 1 || pop_pc_log[0] !== 32'h200) begin
            n_fail++; $display("FAIL misalign_resume got pops=%0d expected first pc 00000200", pop_pc_log.size());
        end
        quiesce();
    endtask

    task automatic test_back_to_back();
        int issued, overlap;
        clear_logs(); extra_lat = 0; issued = 0; overlap = 0;
        cur_pc = (32'($urandom()) % 32'd165430) & ~32'd3;
        for (int i = 0; i < 200 && issued < 20; i++) begin
            cyc(cur_pc, 1'b0, 1'b1, 1'b1, 1'b1);
            if (obs_adv && obs_rv) overlap++;
            if (last_grant) begin
                issued++;
                cur_pc = (32'($urandom()) % 32'd165430) & ~32'd3;
            end
        end
        quiesce();
        n_checks++;
        if (pop_pc_log.size() != 20 || grant_log.size() != 20 || overlap == 0) begin
            n_fail++; $display("FAIL b2b_counts got pops=%0d grants=%0d overlap=%0d expected 20 20 >0",
                               pop_pc_log.size(), grant_log.size(), overlap);
        end
        for (int i = 0; i < pop_pc_log.size() && i < grant_log.size(); i++) begin
            n_checks++;
            if (pop_pc_log[i] !== grant_log[i] || pop_ins_log[i] !== mem_word(grant_log[i])) begin
                n_fail++; $display("FAIL b2b_order[%0d] got pc=%h expected %h", i, pop_pc_log[i], grant_log[i]);
            end
        end
    endtask

    task automatic test_random_traffic();
        logic fl;
        extra_lat = 3;
        for (int i = 0; i < 400; i++) begin
            fl = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                fl = 1'b1;
                cur_pc = 32'($urandom()) & 32'h0000_fffc;
                if ($urandom_range(0, 7) == 0) cur_pc = cur_pc | 32'h2;
            end
            cyc(cur_pc, fl, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
        end
        cur_pc = cur_pc & ~32'd3;
        cyc(cur_pc, 1'b1, 1'b0, 1'b1, 1'b1);
        quiesce();
        extra_lat = 0;
    endtask

    task automatic test_async_reset();
        quiesce(); clear_logs(); extra_lat = 0; cur_pc = 32'h40;
        cyc(cur_pc, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(cur_pc, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (ifc.instr_valid_out !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_valid got=%b expected=1", ifc.instr_valid_out);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (ifc.imem_req_out !== 1'b0 || ifc.pc_advance_out !== 1'b0 || ifc.instr_valid_out !== 1'b0 ||
            ifc.misaligned_out !== 1'b0 || ifc.instr_out !== NOP || ifc.instr_pc_out !== BOOT) begin
            n_fail++; $display("FAIL async_reset got req=%b adv=%b v=%b mis=%b ins=%h pc=%h expected 0 0 0 0 %h %h",
                               ifc.imem_req_out, ifc.pc_advance_out, ifc.instr_valid_out, ifc.misaligned_out,
                               ifc.instr_out, ifc.instr_pc_out, NOP, BOOT);
        end
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        cur_pc = 32'h0000_fffc;
        for (int i = 0; i < 20 && pop_pc_log.size() < 1; i++) cyc(cur_pc, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (pop_pc_log.size() < 1 || pop_pc_log[0] !== 32'h0000_fffc || pop_ins_log[0] !== mem_word(32'h0000_fffc)) begin
            n_fail++; $display("FAIL post_reset_fetch got pops=%0d expected first pc 0000fffc", pop_pc_log.size());
        end
        quiesce();
    endtask

    initial begin
        preload[32'h0] = 32'h0050_0093;
        preload[32'h4] = 32'h00A0_0113;
        preload[32'h8] = 32'h0020_81B3;
        extra_lat = 0; cur_pc = 32'h0; cyc_n = 0;
        model_reset();
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_flush();
        test_misalign();
        test_back_to_back();
        test_random_traffic();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/msrv32_ifetch_unit.md
Name: msrv32_ifetch_unit

Overview:
- Instruction-fetch front end that consumes the PC produced by msrv32_reg_block and drives the instruction-memory request/response interface.
- Returns fetched words to decode through a small FIFO with a valid/ready handshake.
- Generates the PC-advance strobe that tells the PC path when an address has been accepted.
- Handles redirect flushes by discarding in-flight responses, and flags misaligned PCs.

Parameters:
- DEPTH, 2, instruction FIFO entries; also the maximum outstanding imem requests plus buffered entries; power of 2, at least 2
- BOOT_ADDR, 32'h0000_0000, address reported on instr_pc_out while empty after reset

Ports:
- clk_in  input  1  system clock; all state updates on its rising edge
- rst_in  input  1  reset, asynchronous and active-high
- pc_in  input  32  current PC from msrv32_reg_block pc_out
- flush_in  input  1  redirect (branch/jump/trap); valid for one cycle
- imem_req_out  output  1  request valid to instruction memory
- imem_addr_out  output  32  request address (word aligned)
- imem_gnt_in  input  1  memory accepts request this cycle
- imem_rvalid_in  input  1  response data valid; responses arrive in order, at most 1 per cycle
- imem_rdata_in  input  32  response instruction word
- pc_advance_out  output  1  asserted the cycle a request is granted; PC path loads next PC
- instr_valid_out  output  1  FIFO head valid
- instr_out  output  32  FIFO head instruction
- instr_pc_out  output  32  PC of FIFO head
- instr_ready_in  input  1  decode consumes head when valid and ready
- misaligned_out  output  1  pc_in[1:0] != 0 while in RUN; registered, sticky until flush

Behaviour:
- Reset (async, rst_in=1):
  - imem_req_out=0, pc_advance_out=0, instr_valid_out=0, misaligned_out=0.
  - instr_out=32'h0000_0013 (NOP), instr_pc_out=BOOT_ADDR.
  - FIFO empty, outstanding=0, discard=0, FSM=RUN.
  - Reset mid-transaction drops everything; responses arriving after release while discard=0 are accepted.
- Credit rule: imem_req_out=1 only when FSM=RUN, pc_in[1:0]==0, misaligned_out=0, flush_in=0, and outstanding+fifo_count < DEPTH.
- Request path:
  - imem_addr_out=pc_in.
  - pc_advance_out = imem_req_out & imem_gnt_in, combinational.
  - The PC of each granted request is pushed into a DEPTH-entry PC tag queue.
- Response path:
  - On imem_rvalid_in with discard=0, push {tag PC, rdata} into the FIFO and decrement outstanding.
  - With discard>0, drop the data and decrement both discard and outstanding.
- Simultaneous events:
  - Grant+rvalid in the same cycle leaves outstanding unchanged.
  - Push+pop in the same cycle leaves the count unchanged.
  - Pop when empty is ignored.
  - Push when full cannot occur given the credit rule; assert in simulation.
- Latency:
  - Minimum grant-to-instr_valid_out is 1 cycle after rvalid (FIFO registered).
  - No combinational path from imem_rdata_in to instr_out.
- FSM:
  - RUN -> DRAIN on flush_in when outstanding (after this cycle's updates) > 0: discard=outstanding.
  - RUN -> RUN on flush_in when outstanding==0.
  - DRAIN -> RUN when discard reaches 0; requests resume the next cycle.
  - Any flush_in clears the FIFO (instr_valid_out=0 next cycle) and clears misaligned_out.
  - A flush arriving in DRAIN recomputes discard=outstanding.
  - A grant in the same cycle as flush_in cannot happen, because req is masked.
- Misalign:
  - pc_in[1:0]!=0 in RUN with the FIFO drained of older entries sets misaligned_out next cycle.
  - No request is issued until flush_in.
- Counters:
  - outstanding and fifo_count are clog2(DEPTH)+1 bits wide.
  - FIFO pointers wrap modulo DEPTH.

Test Plan:
1. Reset then pc_in=0, gnt=1, rvalid 1 cycle after each grant, ready=1 -> pc_advance_out pulses; instr_pc_out sequence 0x0,0x4,0x8; instr_out matches rdata 0x00500093,0x00A00113,0x002081B3.
2. ready=0 with DEPTH=2, gnt=1 -> exactly 2 grants, then imem_req_out=0. Raise ready -> one new request per pop, no word lost or duplicated.
3. Two requests outstanding (0x10,0x14), flush_in pulse, pc_in->0x100 -> both late responses dropped; first instr_pc_out=0x100; no req while in DRAIN.
4. pc_in=0x0000_0102 -> misaligned_out=1 next cycle, imem_req_out stays 0. flush_in with pc_in=0x200 -> misaligned_out=0, fetch resumes at 0x200.
5. Grant and rvalid in the same cycle plus a pop the same cycle for 20 random addresses (pc_in={$random}%165430 & ~3) -> counts stay in range; output order equals request order.
6. rst_in asserted asynchronously mid-stream with 1 outstanding -> outputs reach their reset values immediately. After release, pc_in=0xffff&~3 fetches correctly.
